// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data ports, data first with a fetch anti-starvation streak limit
module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int WW = $clog2(RD_LAT + 1);
    localparam logic [SW-1:0] S_MAX  = SW'(MAX_DSTREAK);
    localparam logic [WW-1:0] W_LOAD = WW'(RD_LAT - 2);
    typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;
    state_t        state;
    logic          sel_d, is_wr, go, pick_d, cap, fin;
    logic [WW-1:0] wcnt;
    logic [SW-1:0] streak;
    always_comb begin
        go     = state == IDLE && !hold && (if_req || dm_req);
        pick_d = dm_req && !(if_req && streak == S_MAX);
        cap    = state == ACC ? !is_wr && RD_LAT == 1 : state == WAIT && wcnt == '0;
        fin    = cap || (state == ACC && is_wr);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_d     <= 1'b0;
            is_wr     <= 1'b0;
            wcnt      <= '0;
            streak    <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
        end else begin
            if_gnt   <= go && !pick_d;
            dm_gnt   <= go && pick_d;
            ram_wren <= go && pick_d && dm_we;
            if_valid <= cap && !sel_d;
            dm_valid <= fin && sel_d;
            state    <= state == IDLE ? (go ? ACC : IDLE) : state == DONE ? IDLE : fin ? DONE : WAIT;
            wcnt     <= state == ACC ? W_LOAD : wcnt - 1'b1;
            if (state == IDLE && !hold)
                streak <= if_req && pick_d ? streak + 1'b1 : '0;
            if (go) begin
                sel_d    <= pick_d;
                is_wr    <= pick_d && dm_we;
                ram_addr <= pick_d ? dm_addr : if_addr;
                if (pick_d)
                    ram_wdata <= dm_wdata;
            end
            if (cap && sel_d)
                dm_rdata <= ram_q;
            if (cap && !sel_d)
                if_rdata <= ram_q;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int AW = 16, DW = 16, RL = 2, MS = 4;
    logic clk = 0, rst_n = 0, hold = 0, if_req = 0, dm_req = 0, dm_we = 0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0, ram_addr;
    logic [DW-1:0] dm_wdata = '0, if_rdata, dm_rdata, ram_wdata, ram_q;
    logic if_gnt, if_valid, dm_gnt, dm_valid, ram_wren;
    int checks = 0, failures = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_DSTREAK(MS)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM with one output register: q valid two cycles after the address is presented (RL=2)
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr[7:0]] <= ram_wdata;
        ram_q <= mem[ram_addr[7:0]];
    end

    logic [DW-1:0] ref_mem [0:255];
    int cyc = 0, free_c = 0, streak = 0, n_wren = 0, last_iv = -1, last_dv = -1;
    bit armed = 0, pend_if = 0, pend_dm = 0, if_keep = 0, dm_keep = 0;
    bit e_ig [16], e_dg [16], e_iv [16], e_dv [16], e_wr [16], u_i [16], u_d [16];
    logic [AW-1:0] e_addr [16];
    logic [DW-1:0] u_id [16], u_dd [16];
    logic [DW-1:0] x_ird = '0, x_drd = '0;
    int gq_c [$];
    bit gq_d [$];
    bit pat [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predicts future outputs from the inputs presented in the current cycle
    task automatic model_eval();
        int s1 = (cyc + 1) % 16;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                e_ig[i] = 0; e_dg[i] = 0; e_iv[i] = 0; e_dv[i] = 0; e_wr[i] = 0; u_i[i] = 0; u_d[i] = 0;
            end
            u_i[s1] = 1; u_id[s1] = '0; u_d[s1] = 1; u_dd[s1] = '0;
            streak = 0; free_c = cyc + 1; armed = 1;
        end else if (cyc >= free_c && !hold) begin
            if (if_req || dm_req) begin
                bit d = dm_req && !(if_req && streak == MS);
                logic [7:0] a = d ? dm_addr[7:0] : if_addr[7:0];
                streak = (d && if_req) ? streak + 1 : 0;
                e_dg[s1] = d; e_ig[s1] = !d; e_addr[s1] = d ? dm_addr : if_addr; e_wr[s1] = d && dm_we;
                if (d && dm_we) begin
                    ref_mem[a] = dm_wdata;
                    e_dv[(cyc + 2) % 16] = 1;
                    free_c = cyc + 3;
                end else begin
                    int sv = (cyc + 1 + RL) % 16;
                    if (d) begin e_dv[sv] = 1; u_d[sv] = 1; u_dd[sv] = ref_mem[a]; end
                    else begin e_iv[sv] = 1; u_i[sv] = 1; u_id[sv] = ref_mem[a]; end
                    free_c = cyc + RL + 2;
                end
            end else streak = 0;
        end
    endtask

    task automatic step();
        int s;
        model_eval();
        @(negedge clk);
        cyc++;
        s = cyc % 16;
        if (u_i[s]) x_ird = u_id[s];
        if (u_d[s]) x_drd = u_dd[s];
        if (armed) begin
            chk("if_gnt", if_gnt, e_ig[s]);
            chk("dm_gnt", dm_gnt, e_dg[s]);
            chk("if_valid", if_valid, e_iv[s]);
            chk("dm_valid", dm_valid, e_dv[s]);
            chk("ram_wren", ram_wren, e_wr[s]);
            chk("if_rdata", if_rdata, x_ird);
            chk("dm_rdata", dm_rdata, x_drd);
            if (e_ig[s] || e_dg[s]) chk("ram_addr", ram_addr, e_addr[s]);
        end
        if (if_gnt) begin gq_c.push_back(cyc); gq_d.push_back(0); end
        if (dm_gnt) begin gq_c.push_back(cyc); gq_d.push_back(1); end
        if (ram_wren) n_wren++;
        if (if_valid) last_iv = cyc;
        if (dm_valid) last_dv = cyc;
        if (pend_if && !if_keep) if_req = 0;
        if (pend_dm && !dm_keep) dm_req = 0;
        pend_if = e_ig[s]; pend_dm = e_dg[s];
        e_ig[s] = 0; e_dg[s] = 0; e_iv[s] = 0; e_dv[s] = 0; e_wr[s] = 0; u_i[s] = 0; u_d[s] = 0;
    endtask

    task automatic run_grants(input int n);
        int k = 0;
        while (gq_c.size() < n && k < 400) begin step(); k++; end
        chk("grant_count", gq_c.size(), n);
    endtask

    initial begin
        int t0, g;
        for (int i = 0; i < 256; i++) begin
            mem[i] = DW'(i * 16'h0101 ^ 16'h3C00);
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 16'hA5C3; ref_mem[8'h10] = 16'hA5C3;
        // reset with a fetch request pending
        rst_n = 0; if_req = 1; if_addr = 16'h0010;
        step(); step();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_wren", ram_wren, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_valid", dm_valid, 0);
        // fetch read timing, request kept high to observe the return to IDLE at T+4
        rst_n = 1; if_keep = 1; t0 = cyc;
        step();
        chk("t2_gnt", if_gnt, 1);
        chk("t2_addr", ram_addr, 16'h0010);
        step(); step();
        chk("t2_valid", if_valid, 1);
        chk("t2_rdata", if_rdata, 16'hA5C3);
        step(); step();
        chk("t2_regnt_at_t5", if_gnt, 1);
        chk("t2_t0", cyc - t0, 5);
        if_keep = 0;
        repeat (6) step();
        // data write then read back
        dm_req = 1; dm_we = 1; dm_addr = 16'h0020; dm_wdata = 16'h1234; n_wren = 0; t0 = cyc;
        step();
        chk("t3_gnt", dm_gnt, 1);
        chk("t3_wren", ram_wren, 1);
        chk("t3_waddr", ram_addr, 16'h0020);
        chk("t3_wdata", ram_wdata, 16'h1234);
        step();
        chk("t3_valid", dm_valid, 1);
        chk("t3_wren_off", ram_wren, 0);
        repeat (3) step();
        chk("t3_wren_cycles", n_wren, 1);
        dm_req = 1; dm_we = 0; t0 = cyc;
        repeat (6) step();
        chk("t3_rd_valid_cyc", last_dv, t0 + 3);
        chk("t3_rdata", dm_rdata, 16'h1234);
        // both requests held continuously
        gq_c.delete(); gq_d.delete();
        if_keep = 1; dm_keep = 1; if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 16'h0010;
        run_grants(12);
        for (int i = 0; i < 12; i++) chk("t4_order", gq_d[i], pat[i]);
        if_req = 0; gq_c.delete(); gq_d.delete();
        run_grants(3);
        chk("t4_b2b_space", gq_c[1] - gq_c[0], RL + 2);
        chk("t4_b2b_data", gq_d[2], 1);
        if_req = 1; gq_c.delete(); gq_d.delete();
        run_grants(5);
        for (int i = 0; i < 5; i++) chk("t4_after_clear", gq_d[i], pat[i]);
        if_keep = 0; dm_keep = 0; if_req = 0; dm_req = 0;
        repeat (8) step();
        // hold in IDLE, then hold raised during WAIT
        hold = 1; if_req = 1; dm_req = 1; if_addr = 16'h0003; dm_addr = 16'h0004;
        gq_c.delete(); gq_d.delete();
        repeat (10) step();
        chk("t5_hold_gnts", gq_c.size(), 0);
        hold = 0;
        run_grants(2);
        chk("t5_first", gq_d[0], 1);
        chk("t5_second", gq_d[1], 0);
        step();
        hold = 1; if_req = 1; dm_req = 1;
        repeat (8) step();
        chk("t5_wait_valid", last_iv, gq_c[1] + RL);
        chk("t5_no_gnt", gq_c.size(), 2);
        hold = 0;
        repeat (14) step();
        if_req = 0; dm_req = 0;
        repeat (2) step();
        // reset during WAIT of a read
        if_req = 1; if_addr = 16'h0010;
        gq_c.delete(); gq_d.delete();
        run_grants(1);
        g = gq_c[0];
        step();
        rst_n = 0; last_iv = -1;
        step();
        rst_n = 1;
        chk("t6_rst_cyc", cyc, g + 2);
        chk("t6_rdata0", if_rdata, 0);
        repeat (5) step();
        chk("t6_no_valid", last_iv, -1);
        if_req = 1; if_addr = 16'h0020;
        run_grants(2);
        repeat (4) step();
        chk("t6_after", if_rdata, 16'h1234);
        // randomized traffic with occasional hold and reset
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            hold = ($urandom_range(0, 9) == 0);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = AW'($urandom_range(0, 31));
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = AW'($urandom_range(0, 31)); dm_wdata = DW'($urandom);
            end
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
